// File: rtl/e203_irq_sched_pkg.sv
// Shared types and helpers for the E203 interrupt stimulus scheduler.
package e203_irq_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ASSERT = 2'd2,
    ST_DONE   = 2'd3
  } chan_state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Fibonacci step for x^16+x^14+x^13+x^11+1: tap bit k stands for x^(k+1).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned amt);
    logic [31:0] dbl;
    dbl = {v, v} << (amt % 16);
    return dbl[31:16];
  endfunction

endpackage

// File: rtl/e203_irq_sched_chan.sv
// One interrupt channel: IDLE/WAIT/ASSERT/DONE FSM, delay counter and
// (with E203_IRQ_SCHED_TIMEOUT_EN) an ASSERT timeout counter.
module e203_irq_sched_chan #(
  parameter int unsigned DLY_W = 10
`ifdef E203_IRQ_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TO_W  = 12
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_q_i,
  input  logic             ack_i,
  input  logic [DLY_W:0]   dly_i,
  output logic             load_o,
  output logic             ack_acc_o,
  output logic             quiet_d_o,
  output logic             irq_o,
  output logic             timeout_err_o
);
  import e203_irq_sched_pkg::*;

  localparam logic [DLY_W:0] CNT_ONE = 1;

  chan_state_e    state_q, state_d;
  logic [DLY_W:0] cnt_q, cnt_d;
  logic           irq_q, irq_d;

`ifdef E203_IRQ_SCHED_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_ONE = 1;
  logic [TO_W-1:0] to_q, to_d, to_inc;
  logic            to_err_q, to_err_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_o    = 1'b0;
    ack_acc_o = 1'b0;
`ifdef E203_IRQ_SCHED_TIMEOUT_EN
    to_d      = to_q;
    to_err_d  = to_err_q;
    to_inc    = to_q + TO_ONE;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (stop_q_i) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = dly_i;
            load_o  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (stop_q_i) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = ST_ASSERT;
`ifdef E203_IRQ_SCHED_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ASSERT: begin
        if (ack_i) begin
          ack_acc_o = 1'b1;
          if (stop_q_i) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = dly_i;
            load_o  = 1'b1;
          end
        end
`ifdef E203_IRQ_SCHED_TIMEOUT_EN
        // Timeout fires on the cycle the counter would reach all-ones.
        else if (to_inc == '1) begin
          to_err_d = 1'b1;
          if (stop_q_i) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = dly_i;
            load_o  = 1'b1;
          end
        end else begin
          to_d = to_inc;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    irq_d     = (state_d == ST_ASSERT);
    quiet_d_o = (state_d == ST_IDLE) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

`ifdef E203_IRQ_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q     <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_q     <= to_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err_o = to_err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  assign irq_o = irq_q;

endmodule

// File: rtl/e203_irq_sched.sv
// Interrupt stimulus scheduler: shared LFSR, sticky stop, ack counter, quiet flag.
// Optional ASSERT timeout compiled in with E203_IRQ_SCHED_TIMEOUT_EN.
module e203_irq_sched #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DLY_W  = 10,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int unsigned TO_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [NUM_CH-1:0] ack_i,
  output logic [NUM_CH-1:0] irq_o,
  output logic              quiet_o,
  output logic [31:0]       ack_cnt_o,
  output logic [NUM_CH-1:0] timeout_err_o
);
  import e203_irq_sched_pkg::*;

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  logic [15:0]       lfsr_q, lfsr_d;
  logic              stop_q, stop_d;
  logic [31:0]       ack_cnt_q, ack_cnt_d;
  logic              quiet_q, quiet_d;
  logic [NUM_CH-1:0] load, ack_acc, quiet_ch_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int unsigned ROT = (5 * i) % 16;
    localparam logic [DLY_W:0] DLY_ONE = 1;
    logic [15:0]    rot;
    logic [DLY_W:0] dly;

    always_comb begin
      rot = rotl16(lfsr_q, ROT);
      dly = {1'b0, rot[DLY_W-1:0]} + DLY_ONE;
    end

    e203_irq_sched_chan #(
      .DLY_W (DLY_W)
`ifdef E203_IRQ_SCHED_TIMEOUT_EN
      ,
      .TO_W  (TO_W)
`endif
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .stop_q_i      (stop_q),
      .ack_i         (ack_i[i]),
      .dly_i         (dly),
      .load_o        (load[i]),
      .ack_acc_o     (ack_acc[i]),
      .quiet_d_o     (quiet_ch_d[i]),
      .irq_o         (irq_o[i]),
      .timeout_err_o (timeout_err_o[i])
    );
  end

  always_comb begin
    logic [31:0] acc;
    logic [32:0] sum;
    acc = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      acc = acc + {31'b0, ack_acc[k]};
    end
    sum       = {1'b0, ack_cnt_q} + {1'b0, acc};
    ack_cnt_d = sum[32] ? '1 : sum[31:0];
    // Channels loading in the same cycle share one LFSR value; advance once.
    lfsr_d    = (|load) ? lfsr_step(lfsr_q) : lfsr_q;
    stop_d    = stop_q | stop_i;
    quiet_d   = &quiet_ch_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q    <= SEED_EFF;
      stop_q    <= 1'b0;
      ack_cnt_q <= '0;
      quiet_q   <= 1'b1;
    end else begin
      lfsr_q    <= lfsr_d;
      stop_q    <= stop_d;
      ack_cnt_q <= ack_cnt_d;
      quiet_q   <= quiet_d;
    end
  end

  assign quiet_o   = quiet_q;
  assign ack_cnt_o = ack_cnt_q;

endmodule

// File: tb/tb_e203_irq_sched.sv
// Scoreboard bench for e203_irq_sched with SEED=1, DLY_W=4, TO_W=4.
module tb_e203_irq_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [2:0]  ack_i = 3'b000;
  logic [2:0]  irq_o;
  logic        quiet_o;
  logic [31:0] ack_cnt_o;
  logic [2:0]  timeout_err_o;

  int unsigned cyc = 0;
  int unsigned base = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  irq;
    logic [31:0] cnt;
    logic        quiet;
    logic [2:0]  err;
    string       name;
  } exp_t;

  exp_t sb[$];

  e203_irq_sched #(
    .NUM_CH (3),
    .DLY_W  (4),
    .SEED   (16'h0001),
    .TO_W   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .ack_i         (ack_i),
    .irq_o         (irq_o),
    .quiet_o       (quiet_o),
    .ack_cnt_o     (ack_cnt_o),
    .timeout_err_o (timeout_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int unsigned k, input string nm, input logic [2:0] irq,
                      input logic [31:0] cnt, input logic q, input logic [2:0] err);
    exp_t e;
    e.cyc = base + k; e.irq = irq; e.cnt = cnt; e.quiet = q; e.err = err; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic goto(input int unsigned k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares the head expectation on the falling edge of its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          failures++;
          $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
        end else if (irq_o !== e.irq || ack_cnt_o !== e.cnt || quiet_o !== e.quiet ||
                     timeout_err_o !== e.err) begin
          failures++;
          $display("FAIL %s: irq=%b ack_cnt=%0d quiet=%b tmo=%b, required irq=%b ack_cnt=%0d quiet=%b tmo=%b",
                   e.name, irq_o, ack_cnt_o, quiet_o, timeout_err_o, e.irq, e.cnt, e.quiet, e.err);
        end
      end
    end
  end

  initial begin
    push(2, "reset_state", 3'b000, 0, 1'b1, 3'b000);
    goto(3);
    rst  = 1'b0;
    base = cyc;

    // Phase 1: deterministic delays, handshake, spurious ack, simultaneous acks, stop.
    push(9,  "idle_before_start", 3'b000, 0, 1'b1, 3'b000);
    push(10, "armed_wait",        3'b000, 0, 1'b0, 3'b000);
    push(11, "ch1_ch2_d1",        3'b110, 0, 1'b0, 3'b000);
    push(12, "ch0_d2",            3'b111, 0, 1'b0, 3'b000);
    push(13, "ack_ch1_drop",      3'b101, 1, 1'b0, 3'b000);
    push(14, "ch1_reassert_d1",   3'b111, 1, 1'b0, 3'b000);
    push(15, "ack_ch0_drop",      3'b110, 2, 1'b0, 3'b000);
    push(16, "spurious_ack_ch0",  3'b110, 2, 1'b0, 3'b000);
    push(19, "ch0_still_wait",    3'b110, 2, 1'b0, 3'b000);
    push(20, "ch0_d5_assert",     3'b111, 2, 1'b0, 3'b000);
    push(21, "simul_ack",         3'b000, 5, 1'b0, 3'b000);
    push(22, "ch1_ch2_after_sim", 3'b110, 5, 1'b0, 3'b000);
    push(24, "stop_seen",         3'b110, 5, 1'b0, 3'b000);
    push(25, "stop_holds_assert", 3'b110, 5, 1'b0, 3'b000);
    push(26, "ack_ch2_done",      3'b010, 6, 1'b0, 3'b000);
    push(27, "ch1_still_high",    3'b010, 6, 1'b0, 3'b000);
    push(28, "last_done_quiet",   3'b000, 7, 1'b1, 3'b000);
    push(30, "done_terminal",     3'b000, 7, 1'b1, 3'b000);

    goto(9);  start_i = 1'b1;
    goto(10); start_i = 1'b0;
    goto(12); ack_i = 3'b010;
    goto(13); ack_i = 3'b000;
    goto(14); ack_i = 3'b001;
    goto(16); ack_i = 3'b000;
    goto(20); ack_i = 3'b111;
    goto(21); ack_i = 3'b000;
    goto(22); stop_i = 1'b1;
    goto(23); stop_i = 1'b0;
    goto(25); ack_i = 3'b100;
    goto(26); ack_i = 3'b000;
    goto(27); ack_i = 3'b010;
    goto(28); ack_i = 3'b000; start_i = 1'b1;
    goto(29); start_i = 1'b0;
    goto(31); rst = 1'b1;
    goto(33); rst = 1'b0;
    base = cyc;

    // Phase 2: asynchronous reset while ch2 is mid-WAIT.
    push(0, "reset_after_stop", 3'b000, 0, 1'b1, 3'b000);
    push(1, "p2_armed",         3'b000, 0, 1'b0, 3'b000);
    push(2, "p2_ch1_ch2",       3'b110, 0, 1'b0, 3'b000);
    push(3, "async_reset",      3'b000, 0, 1'b1, 3'b000);
    start_i = 1'b1;
    goto(1); start_i = 1'b0;
    goto(2); ack_i = 3'b100;
    goto(3); ack_i = 3'b000; rst = 1'b1;
    goto(5); rst = 1'b0;
    base = cyc;

    // Phase 3: no acks, long ASSERT.
    push(0,  "p3_reset",       3'b000, 0, 1'b1, 3'b000);
    push(2,  "p3_ch1_ch2",     3'b110, 0, 1'b0, 3'b000);
    push(3,  "p3_all",         3'b111, 0, 1'b0, 3'b000);
    push(16, "p3_before_tmo",  3'b111, 0, 1'b0, 3'b000);
`ifdef E203_IRQ_SCHED_TIMEOUT_EN
    push(17, "tmo_ch1_ch2",    3'b001, 0, 1'b0, 3'b110);
    push(18, "tmo_ch0",        3'b110, 0, 1'b0, 3'b111);
`else
    push(17, "hold_no_tmo_a",  3'b111, 0, 1'b0, 3'b000);
    push(18, "hold_no_tmo_b",  3'b111, 0, 1'b0, 3'b000);
`endif
    start_i = 1'b1;
    goto(1); start_i = 1'b0;
    goto(18);

    for (int i = 0; i < 50 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e203_irq_sched.md
# e203_irq_sched

Synthesizable interrupt stimulus scheduler for the E203 SoC verification environment. It drives the external, software and timer interrupt lines into `e203_subsys_main`, replacing the hand-written force loops in the testbench. For each line it waits a pseudo-random number of cycles, asserts the interrupt, and holds it until the handler-done acknowledge. It then repeats until a stop request arrives. The bench instantiates it beside `e203_soc_top` and connects `irq_o` onto `plic_ext_irq`, `clint_sft_irq` and `clint_tmr_irq`.

## Interface
- `NUM_CH`, 3, number of interrupt channels (bit 0 ext, 1 sft, 2 tmr)
- `DLY_W`, 10, delay width; each delay is in the range 1..2^DLY_W cycles
- `SEED`, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1
- `TO_W`, 12, timeout counter width (used only when the timeout feature is compiled in)
- `clk` in 1: the single clock, rising edge
- `rst` in 1: reset, asynchronous and active-high
- `start_i` in 1: arm pulse, driven when the commit PC equals `PC_AFTER_SETMTVEC`
- `stop_i` in 1: stop request, driven when the tohost write count exceeds 32; captured into a sticky latch
- `ack_i` in NUM_CH: per-channel handler-done pulse, driven when the commit PC equals that channel's `*_BEFOR_MRET` PC
- `irq_o` out NUM_CH: interrupt lines, registered
- `quiet_o` out 1: high when every channel is in IDLE or DONE and `irq_o` is 0
- `ack_cnt_o` out 32: total number of accepted acknowledges, saturating
- `timeout_err_o` out NUM_CH: sticky per-channel timeout flag

## Operation
- Per-channel state machine with states IDLE, WAIT, ASSERT, DONE.
- IDLE:
  - `start_i` moves the channel to WAIT and loads `cnt` with D.
  - If `stop_q` is already set, `start_i` moves the channel to DONE instead.
- WAIT:
  - `stop_q` set: go to DONE without asserting.
  - `cnt == 1`: go to ASSERT.
  - Otherwise decrement `cnt`.
- ASSERT:
  - `irq_o[i] = 1`.
  - `ack_i[i]` leads to DONE if `stop_q` is set, or to WAIT (loading a fresh D) otherwise.
  - `stop_i` alone does not end ASSERT; the channel waits for the ack.
- DONE: terminal until reset.
- Ignored inputs:
  - `ack_i[i]` outside ASSERT is ignored and not counted.
  - `start_i` outside IDLE is ignored.
- `stop_q` sets when `stop_i` is high and clears only on reset. A channel sees `stop_q` the cycle after `stop_i`.
- Delay generation:
  - One shared 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Channel i computes D = (rotl(lfsr, 5*i) & (2^DLY_W-1)) + 1. `cnt` is DLY_W+1 bits wide.
  - The LFSR advances one step only on a cycle where at least one channel loads D. Channels that load in the same cycle all use the same LFSR value.
- `ack_cnt_o` adds the popcount of accepted acks each cycle and saturates at 32'hFFFFFFFF.
- Reset values:
  - All channels IDLE.
  - `irq_o = 0`, `quiet_o = 1`, `ack_cnt_o = 0`, `timeout_err_o = 0`, `stop_q = 0`, LFSR = SEED.

## Timing
- If `start_i` is sampled at edge E, the channel is in WAIT after E and `irq_o[i]` rises after edge E+D.
- If `ack_i[i]` is sampled at edge A, `irq_o[i]` is 0 after A. The next assertion follows after edge A+D'.
- The minimum low time between assertions is 1 cycle (D' = 1).
- `quiet_o` is registered and updates together with the state transition.
- Reset mid-operation: all outputs return to their reset values asynchronously, and `irq_o` drops with no handshake.

## Configuration
- `E203_IRQ_SCHED_TIMEOUT_EN` defined:
  - A per-channel TO_W-bit counter runs while the channel is in ASSERT.
  - When it reaches 2^TO_W-1, the channel drops `irq_o[i]`, sets `timeout_err_o[i]`, and moves to WAIT (or to DONE if `stop_q` is set).
  - A timeout does not increment `ack_cnt_o`.
- `E203_IRQ_SCHED_TIMEOUT_EN` undefined: no timeout counters; `timeout_err_o` is tied to 0 and ASSERT waits forever for the ack.

## Structure
- Shared package/defines `e203_irq_sched_pkg`:
  - State encoding (IDLE=2'd0, WAIT=2'd1, ASSERT=2'd2, DONE=2'd3).
  - LFSR tap mask 16'hB400.
  - Default seed.
- Sub-module `e203_irq_sched_chan`: one channel's FSM, delay counter and timeout counter. Generated NUM_CH times.
- The top level holds the LFSR, `stop_q`, the ack counter and the `quiet_o` reduction.

## Test plan
- **Deterministic delays.** SEED=16'h0001, DLY_W=4, `start_i` at edge 10.
  - ch0 has D=2, so `irq_o[0]` is high after edge 12.
  - ch1 and ch2 have D=1, so `irq_o[1]` and `irq_o[2]` are high after edge 11.
  - The LFSR advances exactly once.
- **Ack handshake.** With `irq_o[1]` high, pulse `ack_i[1]` at edge A.
  - `irq_o[1]` is 0 after A and `ack_cnt_o` = 1.
  - ch1 re-enters WAIT with a new D.
- **Spurious ack.** Pulse `ack_i[0]` while ch0 is in WAIT.
  - No state change and `ack_cnt_o` is unchanged.
- **Stop handling.** Pulse `stop_i` while ch0 is in WAIT and ch2 is in ASSERT.
  - ch0 goes to DONE with no assertion.
  - ch2 holds its irq until `ack_i[2]`, then goes to DONE.
  - `quiet_o` = 1 after the last DONE.
- **Simultaneous acks.** `ack_i` = 3'b111 with all channels in ASSERT.
  - `ack_cnt_o` increases by 3 in one cycle and all `irq_o` drop together.
- **Timeout and reset.**
  - With `E203_IRQ_SCHED_TIMEOUT_EN` and TO_W=4, no ack: `irq_o[0]` drops after 15 cycles in ASSERT and `timeout_err_o[0]` = 1.
  - Asserting `rst` mid-WAIT returns all outputs to their reset values immediately.
